// File: rtl/div_share_pkg.sv
// Shared encodings and constants for the shared-divider arbiter.
package div_share_pkg;
    localparam int          DIV_W   = 16;
    localparam logic [15:0] DZ_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div16_restoring.sv
// 16-bit combinational restoring divider; D=0 yields Q=FFFF, R=N.
module div16_restoring (
    input  logic [15:0] n,
    input  logic [15:0] d,
    output logic [15:0] q,
    output logic [15:0] r
);
    logic [16:0] rem;

    always_comb begin
        rem = '0;
        q   = '0;
        for (int i = 15; i >= 0; i--) begin
            rem = {rem[15:0], n[i]};
            if (rem >= {1'b0, d}) begin
                rem  = rem - {1'b0, d};
                q[i] = 1'b1;
            end
        end
        r = rem[15:0];
    end
endmodule

// File: rtl/div_share_arbiter_rr_pick.sv
// Round-robin picker: first asserted req after index last, wrapping.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            j = int'(last) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IW'(j);
                gnt[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/div_share_arbiter.sv
// Arbitrates NREQ requesters onto one shared 16-bit divider, 3 cycles per op.
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] n_in,
    input  logic [NREQ*W-1:0] d_in,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      q_out,
    output logic [W-1:0]      r_out,
    output logic              dz_out,
    output logic              busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t               state, state_nx;
    logic [IW-1:0]        g, last, pick_idx;
    logic [NREQ-1:0]      pick_gnt;
    logic                 pick_any;
    logic [W-1:0]         n_r, d_r, q_div, r_div;
    logic [NREQ-1:0][W-1:0] n_arr, d_arr;

    assign n_arr = n_in;
    assign d_arr = d_in;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req  (req),
        .last (last),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    div16_restoring u_div (
        .n (n_r),
        .d (d_r),
        .q (q_div),
        .r (r_div)
    );

    always_comb begin
        state_nx = state;
        ack      = '0;
        done     = '0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: if (pick_any) state_nx = S_CALC;
            S_CALC: begin
                ack[g]   = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done[g]  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            g      <= '0;
            last   <= IW'(NREQ - 1);
            n_r    <= '0;
            d_r    <= '0;
            q_out  <= '0;
            r_out  <= '0;
            dz_out <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && pick_any) begin
                n_r  <= n_arr[pick_idx];
                d_r  <= d_arr[pick_idx];
                g    <= pick_idx;
                last <= pick_idx;
            end
            // D=0 result forced so it never depends on divider internals
            if (state == S_CALC) begin
                q_out  <= (d_r == '0) ? DZ_QUOT : q_div;
                r_out  <= (d_r == '0) ? n_r : r_div;
                dz_out <= (d_r == '0);
            end
        end
    end
endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one instance of the team's 16-bit combinational restoring divider between NREQ requesters, for example temperature averaging and display scaling.
- Arbitrates round-robin and latches the winner's operands into registers.
- Captures the divider outputs one cycle later and returns quotient and remainder with a per-requester done pulse.
- Sits between the sensor-processing blocks and the single divider, so only one divider is synthesised.

Parameters:
- NREQ, 2, number of requesters (2..4).
- W, 16, operand width; fixed to the divider's 16-bit ports. Must not be overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level. Held high until the matching ack bit is seen.
- n_in  input  NREQ*16  packed dividends; requester k occupies bits [16k+15:16k].
- d_in  input  NREQ*16  packed divisors, same packing as n_in.
- ack  output  NREQ  one-hot, one-cycle pulse: operands accepted.
- done  output  NREQ  one-hot, one-cycle pulse: q_out, r_out and dz_out are valid for that requester.
- q_out  output  16  registered quotient; holds its value until the next done.
- r_out  output  16  registered remainder; holds its value until the next done.
- dz_out  output  1  registered divide-by-zero flag for the result in q_out/r_out.
- busy  output  1  high whenever state is not S_IDLE.

Behaviour:
- Reset: the synchronous rst clears the following.
  - State becomes S_IDLE.
  - ack, done, q_out, r_out and dz_out go to 0; busy goes to 0.
  - The operand registers and grant index go to 0.
  - The round-robin pointer last goes to NREQ-1, so req[0] wins first.
- Reset mid-operation: the in-flight division is discarded and no done is issued. rst has priority over every other event.
- FSM, three states, with T the first cycle:
  - S_IDLE: if req is nonzero at edge T, pick the first asserted requester starting from index (last+1) mod NREQ and wrapping. Latch its n and d into n_r/d_r, store the index in g, set last=g, and go to S_CALC. If req is zero, stay in S_IDLE.
  - S_CALC (cycle T+1): ack[g]=1. The divider is fed from n_r/d_r. At the edge, capture its Q/R into q_out/r_out and set dz_out=(d_r==0). Go to S_DONE.
  - S_DONE (cycle T+2): done[g]=1. At the edge, go to S_IDLE.
- Latency and throughput: request sampled at T, ack at T+1, done at T+2. Maximum throughput is one division per 3 cycles per shared divider.
- Request level during S_CALC and S_DONE: req is ignored. A requester that deasserts req on seeing ack is not regranted. If req is still high in S_IDLE, it re-enters arbitration as a new request.
- Divide by zero: q_out is forced to 16'hFFFF, r_out to n_r, and dz_out to 1. These values are identical to the divider's natural output for D=0; they are forced explicitly so the result does not depend on the divider.
- Result: q_out = n_r / d_r and r_out = n_r % d_r (unsigned) when d_r != 0.
- Simultaneous requests: the round-robin rule alone decides the winner. No requester waits more than NREQ-1 grants.
- Operands: only the values present at edge T are used. Changes to n_in/d_in after T have no effect on the in-flight operation.
- Outputs: ack, done and busy are registered or decoded from state and g only, with no combinational path from req.

Decomposition:
- Shared package/include, div_share_pkg.vh:
  - State encodings S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2.
  - DIV_W=16.
  - DZ_QUOT=16'hFFFF.
- Sub-module rr_pick (NREQ): combinational round-robin picker from req and last to a one-hot grant and its index.
- The existing divider is instantiated once, unmodified, with N=n_r, D=d_r.

Test Plan:
1. Single request: req[0]=1, n=1000, d=7 at T -> ack[0] at T+1; done[0] at T+2 with q=142, r=6, dz=0; busy high T+1..T+2.
2. Divide by zero: req[1]=1, n=0x1234, d=0 -> done[1] with q=0xFFFF, r=0x1234, dz=1.
3. Contention from reset: req=2'b11 held continuously, requester 0 n=50 d=5, requester 1 n=9 d=4.
   - Grants go 0, 1, 0, 1, with a done every 3 cycles.
   - Results alternate between q=10 r=0 and q=2 r=1.
4. Operand stability: change n_in[0] to 0xFFFF at T+1 after a request with n=100, d=10 -> result is still q=10, r=0.
5. Reset in S_CALC: rst=1 at T+1 -> no done at any later cycle; all outputs 0; next request from req[1] alone is granted normally.
6. Boundary values:
   - n=0xFFFF, d=1 -> q=0xFFFF, r=0, dz=0.
   - n=5, d=0xFFFF -> q=0, r=5.
   - n=0, d=3 -> q=0, r=0.
